// File: rtl/mem_io_access_unit.sv
// Load/store responder: single-cycle RAM stores, sync-RAM loads, ack-based IO accesses with timeout.
// Latency: store 1 cycle, RAM load 3 cycles, IO access N+3 cycles for an ack in wait cycle N.
// Backpressure: stall holds the pipeline while a load or IO access is in flight; released in DONE.
module mem_io_access_unit #(
    parameter int          RAM_ADDR_W   = 14,
    parameter int          IO_ADDR_W    = 16,
    parameter int          IO_TIMEOUT   = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  IORead,
    input  logic                  IOWrite,
    input  logic [31:0]           ALU_result,
    input  logic [31:0]           store_data,
    output logic [31:0]           mem_data,
    output logic                  stall,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_we,
    input  logic [31:0]           ram_rdata,
    output logic [IO_ADDR_W-1:0]  io_addr,
    output logic [31:0]           io_wdata,
    output logic                  io_rd_req,
    output logic                  io_wr_req,
    input  logic                  io_ack,
    input  logic [31:0]           io_rdata,
    output logic                  err_flag,
    input  logic                  err_clear
);

    localparam int CNT_W = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, MEM_RD, IO_WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] io_cnt;
    logic             any_strobe, misaligned, multi_strobe, idle_go;
    logic             sel_mw, sel_mr, sel_iw, sel_ir;
    logic             io_timeout, stall_c, err_set;
    logic             unused_bits;

    assign ram_addr    = ALU_result[RAM_ADDR_W+1:2];
    assign ram_wdata   = store_data;
    assign unused_bits = ^ALU_result;

    assign any_strobe   = MemRead | MemWrite | IORead | IOWrite;
    assign misaligned   = any_strobe && (ALU_result[1:0] != 2'b00);
    assign multi_strobe = $countones({MemRead, MemWrite, IORead, IOWrite}) > 1;
    assign idle_go      = (state == IDLE) && reset_n && !misaligned;

    // Fixed priority: MemWrite > MemRead > IOWrite > IORead
    assign sel_mw = idle_go && MemWrite;
    assign sel_mr = idle_go && !MemWrite && MemRead;
    assign sel_iw = idle_go && !MemWrite && !MemRead && IOWrite;
    assign sel_ir = idle_go && !MemWrite && !MemRead && !IOWrite && IORead;

    assign io_timeout = (state == IO_WAIT) && !io_ack && (io_cnt == CNT_W'(IO_TIMEOUT - 1));

    assign ram_we = sel_mw;
    // Gated by reset_n so the PC is released the moment reset asserts
    assign stall  = stall_c && reset_n;

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    err_set = 1'b1;
                end else begin
                    err_set = multi_strobe;
                    if (sel_mr) begin
                        stall_c   = 1'b1;
                        state_nxt = MEM_RD;
                    end else if (sel_iw || sel_ir) begin
                        stall_c   = 1'b1;
                        state_nxt = IO_WAIT;
                    end
                end
            end
            MEM_RD: begin
                stall_c   = 1'b1;
                state_nxt = DONE;
            end
            IO_WAIT: begin
                stall_c = 1'b1;
                err_set = io_timeout;
                if (io_ack || io_timeout) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_data  <= '0;
            io_addr   <= '0;
            io_wdata  <= '0;
            io_rd_req <= 1'b0;
            io_wr_req <= 1'b0;
            io_cnt    <= '0;
            err_flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (misaligned) mem_data <= '0;
                    if (sel_iw || sel_ir) begin
                        io_addr   <= ALU_result[IO_ADDR_W-1:0];
                        io_wdata  <= store_data;
                        io_rd_req <= sel_ir;
                        io_wr_req <= sel_iw;
                        io_cnt    <= '0;
                    end
                end
                MEM_RD: mem_data <= ram_rdata;
                IO_WAIT: begin
                    // An ack arriving in the timeout cycle takes precedence
                    if (io_ack) begin
                        io_rd_req <= 1'b0;
                        io_wr_req <= 1'b0;
                        if (io_rd_req) mem_data <= io_rdata;
                    end else if (io_timeout) begin
                        io_rd_req <= 1'b0;
                        io_wr_req <= 1'b0;
                        if (io_rd_req) mem_data <= TIMEOUT_DATA;
                    end else begin
                        io_cnt <= io_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (err_set)        err_flag <= 1'b1;
            else if (err_clear) err_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_io_access_unit.sv
module tb_mem_io_access_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        MemRead, MemWrite, IORead, IOWrite;
    logic [31:0] ALU_result, store_data;
    logic [31:0] mem_data;
    logic        stall;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [15:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_rd_req, io_wr_req, io_ack;
    logic [31:0] io_rdata;
    logic        err_flag, err_clear;

    int tests = 0;
    int fails = 0;

    logic [31:0] ram [0:15];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_we) ram[ram_addr[3:0]] <= ram_wdata;
        ram_rdata <= ram[ram_addr[3:0]];
    end

    mem_io_access_unit #(
        .RAM_ADDR_W(14), .IO_ADDR_W(16), .IO_TIMEOUT(4), .TIMEOUT_DATA(32'hDEADBEEF)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .IORead(IORead), .IOWrite(IOWrite),
        .ALU_result(ALU_result), .store_data(store_data),
        .mem_data(mem_data), .stall(stall),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rd_req(io_rd_req), .io_wr_req(io_wr_req),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .err_flag(err_flag), .err_clear(err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        reset_n = 1'b0; MemRead = 0; MemWrite = 0; IORead = 0; IOWrite = 0;
        ALU_result = 0; store_data = 0; io_ack = 0; io_rdata = 0; err_clear = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_rd_req", {31'h0, io_rd_req}, 32'h0);
        chk("rst_wr_req", {31'h0, io_wr_req}, 32'h0);
        chk("rst_err", {31'h0, err_flag}, 32'h0);
        chk("rst_io_addr", {16'h0, io_addr}, 32'h0);
        #1 reset_n = 1'b1;
        tick();

        // RAM store then load at 0x10
        MemWrite = 1; ALU_result = 32'h10; store_data = 32'hA5A5_0001;
        #1;
        chk("st_we", {31'h0, ram_we}, 32'h1);
        chk("st_addr", {18'h0, ram_addr}, 32'h4);
        chk("st_stall", {31'h0, stall}, 32'h0);
        tick();
        MemWrite = 0;
        #1;
        chk("st_we_off", {31'h0, ram_we}, 32'h0);
        MemRead = 1;
        #1;
        chk("ld_stall_idle", {31'h0, stall}, 32'h1);
        tick();
        chk("ld_stall_memrd", {31'h0, stall}, 32'h1);
        tick();
        chk("ld_stall_done", {31'h0, stall}, 32'h0);
        chk("ld_data", mem_data, 32'hA5A5_0001);
        MemRead = 0;
        tick();

        // IO read, ack in wait cycle 3
        IORead = 1; ALU_result = 32'hFC60;
        #1;
        chk("ior_stall_idle", {31'h0, stall}, 32'h1);
        chk("ior_req_idle", {31'h0, io_rd_req}, 32'h0);
        tick();
        chk("ior_addr", {16'h0, io_addr}, 32'hFC60);
        for (int c = 0; c < 4; c++) begin
            chk("ior_req_wait", {31'h0, io_rd_req}, 32'h1);
            chk("ior_stall_wait", {31'h0, stall}, 32'h1);
            if (c == 3) begin io_ack = 1; io_rdata = 32'h1234; end
            tick();
        end
        io_ack = 0; io_rdata = 0;
        chk("ior_req_done", {31'h0, io_rd_req}, 32'h0);
        chk("ior_stall_done", {31'h0, stall}, 32'h0);
        chk("ior_data", mem_data, 32'h1234);
        chk("ior_err", {31'h0, err_flag}, 32'h0);
        IORead = 0;
        tick();

        // IO write timeout
        IOWrite = 1; ALU_result = 32'h40; store_data = 32'h77;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("iow_req_wait", {31'h0, io_wr_req}, 32'h1);
            tick();
        end
        chk("iow_req_drop", {31'h0, io_wr_req}, 32'h0);
        chk("iow_err", {31'h0, err_flag}, 32'h1);
        chk("iow_wdata", io_wdata, 32'h77);
        chk("iow_stall_done", {31'h0, stall}, 32'h0);
        chk("iow_data_kept", mem_data, 32'h1234);
        IOWrite = 0;
        tick();

        // IO read timeout
        IORead = 1; ALU_result = 32'h44;
        repeat (5) tick();
        chk("iort_data", mem_data, 32'hDEADBEEF);
        chk("iort_req", {31'h0, io_rd_req}, 32'h0);
        IORead = 0;
        err_clear = 1;
        tick();
        err_clear = 0;
        chk("iort_clear", {31'h0, err_flag}, 32'h0);

        // Misaligned load
        MemRead = 1; ALU_result = 32'h13;
        #1;
        chk("mis_stall", {31'h0, stall}, 32'h0);
        chk("mis_we", {31'h0, ram_we}, 32'h0);
        tick();
        MemRead = 0;
        chk("mis_data", mem_data, 32'h0);
        chk("mis_err", {31'h0, err_flag}, 32'h1);
        err_clear = 1;
        tick();
        err_clear = 0;
        chk("mis_clear", {31'h0, err_flag}, 32'h0);

        // MemWrite + IOWrite together
        MemWrite = 1; IOWrite = 1; ALU_result = 32'h20; store_data = 32'hCAFE_0002;
        #1;
        chk("multi_we", {31'h0, ram_we}, 32'h1);
        chk("multi_stall", {31'h0, stall}, 32'h0);
        tick();
        MemWrite = 0; IOWrite = 0;
        chk("multi_wr_req", {31'h0, io_wr_req}, 32'h0);
        chk("multi_err", {31'h0, err_flag}, 32'h1);
        tick();
        chk("multi_wr_req2", {31'h0, io_wr_req}, 32'h0);
        MemRead = 1;
        repeat (2) tick();
        chk("multi_readback", mem_data, 32'hCAFE_0002);
        MemRead = 0;
        tick();

        // Reset asserted during IO_WAIT
        IORead = 1; ALU_result = 32'h80;
        repeat (2) tick();
        chk("rmid_req_before", {31'h0, io_rd_req}, 32'h1);
        reset_n = 0;
        #1;
        chk("rmid_req", {31'h0, io_rd_req}, 32'h0);
        chk("rmid_stall", {31'h0, stall}, 32'h0);
        chk("rmid_data", mem_data, 32'h0);
        chk("rmid_err", {31'h0, err_flag}, 32'h0);
        IORead = 0;
        tick();
        reset_n = 1;
        tick();
        IORead = 1; ALU_result = 32'h84;
        tick();
        chk("post_req", {31'h0, io_rd_req}, 32'h1);
        io_ack = 1; io_rdata = 32'h5555_AAAA;
        tick();
        io_ack = 0; IORead = 0;
        chk("post_data", mem_data, 32'h5555_AAAA);
        chk("post_stall", {31'h0, stall}, 32'h0);
        chk("post_err", {31'h0, err_flag}, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
